// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: AXI-Lite response codes and the read-checker FSM state type
package axi_lite_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;
endpackage

// File: rtl/axi_read_checker_if.sv
// axi_read_checker_if: AXI4-Lite read-address and read-data channels
interface axi_read_checker_if #(parameter int AW = 32, parameter int DW = 32);
  logic [AW-1:0] araddr;
  logic [2:0]    arprot;
  logic          arvalid;
  logic          arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready;
  modport master (output araddr, arprot, arvalid, rready, input arready, rdata, rresp, rvalid);
  modport slave  (input araddr, arprot, arvalid, rready, output arready, rdata, rresp, rvalid);
endinterface

// File: rtl/pulse_gen.sv
// pulse_gen: registered rising-edge detector, one-cycle pulse per 0->1 of d
module pulse_gen (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic d_q;
  // history resets high so a level held through reset needs a fresh 0->1
  always_ff @(posedge clk)
    if (rst) begin
      d_q <= 1'b1;
      q   <= 1'b0;
    end else begin
      d_q <= d;
      q   <= d & ~d_q;
    end
endmodule

// File: rtl/axi_read_checker.sv
// axi_read_checker: AXI4-Lite master reading N words and checking them against an incrementing pattern
module axi_read_checker
  import axi_lite_pkg::*;
#(
  parameter logic [31:0] C_M_TARGET_SLAVE_BASE_ADDR = 32'h4000_0000,
  parameter logic [31:0] C_M_START_DATA_VALUE       = 32'hAA00_0000,
  parameter int          C_M_TRANSACTIONS_NUM       = 4,
  parameter int          C_M_AXI_ADDR_WIDTH         = 32,
  parameter int          C_M_AXI_DATA_WIDTH         = 32
) (
  input  logic       ACLK,
  input  logic       ARESET,
  input  logic       INIT_AXI_TXN,
  output logic       TXN_DONE,
  output logic       ERROR,
  output logic [8:0] MISMATCH_COUNT,
  axi_read_checker_if.master axi
);
  localparam logic [7:0] LAST = 8'(C_M_TRANSACTIONS_NUM - 1);
  state_t state, next;
  logic start, launch, beat, fail;
  logic [7:0] idx;
  logic [C_M_AXI_DATA_WIDTH-1:0] expected;
  pulse_gen u_start (.clk(ACLK), .rst(ARESET), .d(INIT_AXI_TXN), .q(start));
  assign launch   = start && (state == IDLE || state == DONE);
  assign beat     = axi.rvalid && axi.rready;
  assign expected = C_M_AXI_DATA_WIDTH'(C_M_START_DATA_VALUE + 32'(idx));
  assign fail     = axi.rresp == RESP_SLVERR || axi.rresp == RESP_DECERR || axi.rdata != expected;
  assign axi.araddr  = C_M_AXI_ADDR_WIDTH'(C_M_TARGET_SLAVE_BASE_ADDR + {22'd0, idx, 2'b00});
  assign axi.arprot  = 3'b000;
  assign axi.arvalid = state == ADDR;
  assign axi.rready  = state == DATA;
  always_ff @(posedge ACLK) state <= ARESET ? IDLE : next;
  always_comb begin
    next = state;
    next = launch                         ? ADDR
         : state == ADDR && axi.arready   ? DATA
         : beat                           ? (idx == LAST ? DONE : ADDR)
         : state;
  end
  // a new run clears the previous run's results on the cycle it is launched
  always_ff @(posedge ACLK)
    if (ARESET || launch) begin
      idx            <= '0;
      TXN_DONE       <= 1'b0;
      ERROR          <= 1'b0;
      MISMATCH_COUNT <= '0;
    end else if (beat) begin
      ERROR          <= ERROR | fail;
      MISMATCH_COUNT <= MISMATCH_COUNT + 9'(fail && MISMATCH_COUNT != 9'h1FF);
      TXN_DONE       <= idx == LAST;
      idx            <= idx == LAST ? idx : idx + 8'd1;
    end
endmodule

// File: tb/tb_axi_read_checker.sv
// tb_axi_read_checker: table-driven and randomized runs against a behavioural slave/result model
module tb_axi_read_checker;
  localparam logic [31:0] BASE  = 32'h4000_0000;
  localparam logic [31:0] START = 32'hAA00_0000;
  localparam int N = 4;
  logic ACLK = 1'b0, ARESET = 1'b1, INIT_AXI_TXN = 1'b0;
  logic TXN_DONE, ERROR;
  logic [8:0] MISMATCH_COUNT;
  axi_read_checker_if bus();
  axi_read_checker #(
    .C_M_TARGET_SLAVE_BASE_ADDR(BASE), .C_M_START_DATA_VALUE(START), .C_M_TRANSACTIONS_NUM(N),
    .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .INIT_AXI_TXN(INIT_AXI_TXN), .TXN_DONE(TXN_DONE),
    .ERROR(ERROR), .MISMATCH_COUNT(MISMATCH_COUNT), .axi(bus)
  );
  always #5 ACLK = ~ACLK;
  int vectors = 0, miscompares = 0, ar_hs = 0, r_hs = 0;
  always @(posedge ACLK) begin
    if (bus.arvalid && bus.arready) ar_hs <= ar_hs + 1;
    if (bus.rvalid && bus.rready) r_hs <= r_hs + 1;
  end
  logic [31:0] cfg_data[N];
  logic [1:0]  cfg_resp[N];
  int          cfg_ard[N], cfg_rd[N];
  typedef struct {
    string      name;
    logic [3:0] bad;
    logic [7:0] resp;
    int         ard;
    int         rd;
    logic       err;
    logic [8:0] cnt;
  } vec_t;
  vec_t tbl[6];
  task automatic tick;
    @(posedge ACLK);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  task automatic fill(input logic [3:0] bad, input logic [7:0] resp, input int ard, input int rd);
    for (int i = 0; i < N; i++) begin
      cfg_data[i] = bad[i] ? 32'hDEAD_0011 : START + 32'(i);
      cfg_resp[i] = resp[2*i +: 2];
      cfg_ard[i]  = ard;
      cfg_rd[i]   = rd;
    end
  endtask
  // result of a whole run from the rules: every failing beat counts once, capped at 511
  function automatic void model(output logic e, output logic [8:0] c);
    int f = 0;
    for (int i = 0; i < N; i++)
      if (cfg_resp[i] >= 2'd2 || cfg_data[i] != START + 32'(i)) f++;
    e = f > 0;
    c = 9'(f > 511 ? 511 : f);
  endfunction
  task automatic start_run;
    INIT_AXI_TXN = 1'b0;
    tick;
    INIT_AXI_TXN = 1'b1;
    tick;
    chk("latency_1", 32'(bus.arvalid), 32'd0);
    tick;
    chk("latency_2", 32'(bus.arvalid), 32'd1);
  endtask
  task automatic serve_ar(input int i);
    int t = 0;
    logic [31:0] a;
    while (!bus.arvalid && t < 64) begin tick; t++; end
    chk("arvalid_wait", 32'(bus.arvalid), 32'd1);
    a = bus.araddr;
    chk($sformatf("araddr_%0d", i), a, BASE + 32'(4 * i));
    for (int k = 0; k < cfg_ard[i]; k++) begin
      tick;
      chk("ar_hold", 32'(bus.arvalid && bus.araddr == a && !bus.rready), 32'd1);
    end
    bus.arready = 1'b1;
    tick;
    bus.arready = 1'b0;
    chk("in_data", {30'd0, bus.rready, bus.arvalid}, 32'd2);
  endtask
  task automatic serve_r(input int i);
    int t = 0;
    repeat (cfg_rd[i]) tick;
    bus.rvalid = 1'b1;
    bus.rdata  = cfg_data[i];
    bus.rresp  = cfg_resp[i];
    while (!bus.rready && t < 64) begin tick; t++; end
    chk("rready_wait", 32'(bus.rready), 32'd1);
    tick;
    bus.rvalid = 1'b0;
    bus.rdata  = '0;
    bus.rresp  = '0;
  endtask
  task automatic run_cfg(input string name, input logic e, input logic [8:0] c);
    int h0;
    start_run;
    h0 = ar_hs;
    for (int i = 0; i < N; i++) begin
      serve_ar(i);
      if (i == N - 1) chk({name, "_done_early"}, 32'(TXN_DONE), 32'd0);
      serve_r(i);
    end
    chk({name, "_done"}, 32'(TXN_DONE), 32'd1);
    chk({name, "_error"}, 32'(ERROR), 32'(e));
    chk({name, "_count"}, 32'(MISMATCH_COUNT), 32'(c));
    chk({name, "_ar_handshakes"}, 32'(ar_hs - h0), 32'(N));
    repeat (3) tick;
    chk({name, "_no_retrigger"}, {30'd0, bus.arvalid, TXN_DONE}, 32'd1);
  endtask
  initial begin
    logic e;
    logic [8:0] c;
    int h0;
    tbl[0] = '{"clean",        4'b0000, 8'h00, 0, 0, 1'b0, 9'd0};
    tbl[1] = '{"bad_beat2",    4'b0100, 8'h00, 0, 1, 1'b1, 9'd1};
    tbl[2] = '{"slverr_exok",  4'b0000, 8'h48, 1, 0, 1'b1, 9'd1};
    tbl[3] = '{"arready_wait", 4'b0000, 8'h00, 5, 0, 1'b0, 9'd0};
    tbl[4] = '{"all_fail",     4'b1111, 8'hFF, 0, 2, 1'b1, 9'd4};
    tbl[5] = '{"decerr_bad",   4'b0001, 8'h03, 2, 0, 1'b1, 9'd1};
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    bus.rdata   = '0;
    bus.rresp   = '0;
    repeat (3) tick;
    chk("rst_arvalid", 32'(bus.arvalid), 32'd0);
    chk("rst_rready", 32'(bus.rready), 32'd0);
    chk("rst_araddr", bus.araddr, BASE);
    chk("rst_arprot", 32'(bus.arprot), 32'd0);
    chk("rst_outputs", {22'd0, TXN_DONE, ERROR, MISMATCH_COUNT}, 32'd0);
    ARESET = 1'b0;
    repeat (3) tick;
    chk("idle_no_start", 32'(bus.arvalid), 32'd0);
    foreach (tbl[v]) begin
      fill(tbl[v].bad, tbl[v].resp, tbl[v].ard, tbl[v].rd);
      run_cfg(tbl[v].name, tbl[v].err, tbl[v].cnt);
    end
    repeat (20) begin
      for (int i = 0; i < N; i++) begin
        cfg_data[i] = $urandom_range(0, 3) == 0 ? $urandom : START + 32'(i);
        cfg_resp[i] = 2'($urandom_range(0, 3));
        cfg_ard[i]  = $urandom_range(0, 3);
        cfg_rd[i]   = $urandom_range(0, 3);
      end
      model(e, c);
      run_cfg("rand", e, c);
    end
    // R beat offered outside DATA must not be taken
    h0 = r_hs;
    bus.rvalid = 1'b1;
    bus.rdata  = 32'hBAD0_BAD0;
    bus.rresp  = 2'b11;
    repeat (3) begin
      tick;
      chk("r_outside_rready", 32'(bus.rready), 32'd0);
    end
    bus.rvalid = 1'b0;
    chk("r_outside_taken", 32'(r_hs - h0), 32'd0);
    // reset in DATA of beat 2 after a failing beat 0
    fill(4'b0001, 8'h00, 0, 0);
    start_run;
    serve_ar(0); serve_r(0); serve_ar(1); serve_r(1); serve_ar(2);
    chk("pre_rst_error", 32'(ERROR), 32'd1);
    ARESET = 1'b1;
    tick;
    ARESET = 1'b0;
    chk("mid_rst_arvalid", 32'(bus.arvalid), 32'd0);
    chk("mid_rst_rready", 32'(bus.rready), 32'd0);
    chk("mid_rst_araddr", bus.araddr, BASE);
    chk("mid_rst_outputs", {22'd0, TXN_DONE, ERROR, MISMATCH_COUNT}, 32'd0);
    repeat (10) tick;
    chk("held_init_no_start", 32'(bus.arvalid), 32'd0);
    fill(4'b0000, 8'h00, 0, 0);
    run_cfg("after_rst", 1'b0, 9'd0);
    // start edge in DATA ignored, then start in DONE clears the failing run
    fill(4'b0100, 8'h00, 0, 0);
    start_run;
    h0 = ar_hs;
    serve_ar(0); serve_r(0); serve_ar(1);
    INIT_AXI_TXN = 1'b0;
    tick;
    INIT_AXI_TXN = 1'b1;
    tick;
    tick;
    chk("data_start_ignored", {30'd0, bus.rready, bus.arvalid}, 32'd2);
    serve_r(1); serve_ar(2); serve_r(2); serve_ar(3); serve_r(3);
    chk("ign_done", 32'(TXN_DONE), 32'd1);
    chk("ign_error", 32'(ERROR), 32'd1);
    chk("ign_count", 32'(MISMATCH_COUNT), 32'd1);
    chk("ign_ar_handshakes", 32'(ar_hs - h0), 32'(N));
    fill(4'b0000, 8'h00, 0, 0);
    start_run;
    chk("restart_clear", {22'd0, TXN_DONE, ERROR, MISMATCH_COUNT}, 32'd0);
    for (int i = 0; i < N; i++) begin serve_ar(i); serve_r(i); end
    chk("restart_done", 32'(TXN_DONE), 32'd1);
    chk("restart_result", {22'd0, ERROR, MISMATCH_COUNT}, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
